// File: rtl/sft_chain_pkg.sv
// Shared types for the 74HC595 chain driver: command codes, FSM states and the
// layout of one queued command.
package sft_chain_pkg;

    localparam int SFT_ENTRY_W = 11;

    typedef enum logic [1:0] {
        SFT_CMD_MR = 2'b00,
        SFT_CMD_SH = 2'b01,
        SFT_CMD_ST = 2'b10,
        SFT_CMD_OE = 2'b11
    } sft_cmd_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MR    = 3'd2,
        S_SH_LO = 3'd3,
        S_SH_HI = 3'd4,
        S_ST    = 3'd5,
        S_DONE  = 3'd6
    } sft_state_e;

    typedef struct packed {
        sft_cmd_e   cmd;
        logic       oen;
        logic [7:0] din;
    } sft_entry_t;

endpackage

// File: rtl/sft_cmd_fifo.sv
// Small synchronous command FIFO; push is refused when full and pop when empty,
// so a full FIFO never accepts a write even if a pop happens in the same cycle.
module sft_cmd_fifo
    import sft_chain_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [SFT_ENTRY_W-1:0] din_i,
    output logic [SFT_ENTRY_W-1:0] dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [SFT_ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [PTR_W:0]         count_q;
    logic                   push_ok;
    logic                   pop_ok;

    assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge CLK_I) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Power-of-two depth lets the pointers wrap on their own.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sft_chain_drv.sv
// Buffered 74HC595 chain driver: queues CPU commands and plays them out as
// registered SHCP/DS/STCP/MR_N/OE_N pin activity.
module sft_chain_drv
    import sft_chain_pkg::*;
#(
    parameter int DIV        = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       wr_vld,
    input  logic [1:0] wr_cmd,
    input  logic       wr_oen,
    input  logic [7:0] wr_din,
    output logic       wr_rdy,
    output logic       busy,
    output logic       done,
    output logic       ovf,
    input  logic       ovf_clr,
    output logic       sft_shcp,
    output logic       sft_ds,
    output logic       sft_stcp,
    output logic       sft_mr_n,
    output logic       sft_oe_n
);

    localparam int         CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0] PH_RELOAD = 8'(DIV - 1);

    sft_state_e             state_q, state_d;
    sft_entry_t             entry_q, entry_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             phase_q, phase_d;
    logic                   shcp_q, shcp_d;
    logic                   ds_q, ds_d;
    logic                   stcp_q, stcp_d;
    logic                   mr_n_q, mr_n_d;
    logic                   oe_n_q, oe_n_d;
    logic                   ovf_q;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic [SFT_ENTRY_W-1:0] fifo_dout;
    logic [2:0]             bit_nxt;

    sft_cmd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .CLK_I   (CLK_I),
        .RST_I   (RST_I),
        .push_i  (wr_vld && wr_rdy),
        .pop_i   (fifo_pop),
        .din_i   ({wr_cmd, wr_oen, wr_din}),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign wr_rdy   = !fifo_full;
    assign busy     = (state_q != S_IDLE) || (fifo_count != '0);
    assign done     = (state_q == S_DONE);
    assign ovf      = ovf_q;
    assign sft_shcp = shcp_q;
    assign sft_ds   = ds_q;
    assign sft_stcp = stcp_q;
    assign sft_mr_n = mr_n_q;
    assign sft_oe_n = oe_n_q;
    assign bit_nxt  = bit_q - 3'd1;

    // A dropped write outranks a clear in the same cycle.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I)                   ovf_q <= 1'b0;
        else if (wr_vld && !wr_rdy)  ovf_q <= 1'b1;
        else if (ovf_clr)            ovf_q <= 1'b0;
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= S_IDLE;
            entry_q <= '0;
            bit_q   <= '0;
            phase_q <= '0;
            shcp_q  <= 1'b0;
            ds_q    <= 1'b0;
            stcp_q  <= 1'b0;
            mr_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            shcp_q  <= shcp_d;
            ds_q    <= ds_d;
            stcp_q  <= stcp_d;
            mr_n_q  <= mr_n_d;
            oe_n_q  <= oe_n_d;
        end
    end

    // MR and ST reuse the bit counter as a two-pass counter so each pulse
    // lasts 2*DIV cycles without widening the 8-bit phase counter.
    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        bit_d    = bit_q;
        phase_d  = phase_q;
        shcp_d   = shcp_q;
        ds_d     = ds_q;
        stcp_d   = stcp_q;
        mr_n_d   = mr_n_q;
        oe_n_d   = oe_n_q;
        fifo_pop = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    entry_d  = sft_entry_t'(fifo_dout);
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                phase_d = PH_RELOAD;
                case (entry_q.cmd)
                    SFT_CMD_MR: begin
                        mr_n_d  = 1'b0;
                        bit_d   = 3'd1;
                        state_d = S_MR;
                    end
                    SFT_CMD_SH: begin
                        shcp_d  = 1'b0;
                        ds_d    = entry_q.din[7];
                        bit_d   = 3'd7;
                        state_d = S_SH_LO;
                    end
                    SFT_CMD_ST: begin
                        stcp_d  = 1'b1;
                        bit_d   = 3'd1;
                        state_d = S_ST;
                    end
                    default: begin
                        oe_n_d  = entry_q.oen;
                        state_d = S_DONE;
                    end
                endcase
            end
            S_MR, S_ST: begin
                if (phase_q != 8'd0) begin
                    phase_d = phase_q - 8'd1;
                end else if (bit_q != 3'd0) begin
                    bit_d   = bit_nxt;
                    phase_d = PH_RELOAD;
                end else begin
                    mr_n_d  = 1'b1;
                    stcp_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_SH_LO: begin
                if (phase_q != 8'd0) begin
                    phase_d = phase_q - 8'd1;
                end else begin
                    shcp_d  = 1'b1;
                    phase_d = PH_RELOAD;
                    state_d = S_SH_HI;
                end
            end
            S_SH_HI: begin
                if (phase_q != 8'd0) begin
                    phase_d = phase_q - 8'd1;
                end else if (bit_q != 3'd0) begin
                    shcp_d  = 1'b0;
                    ds_d    = entry_q.din[bit_nxt];
                    bit_d   = bit_nxt;
                    phase_d = PH_RELOAD;
                    state_d = S_SH_LO;
                end else begin
                    shcp_d  = 1'b0;
                    ds_d    = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sft_chain_drv.sv
// Directed bench for sft_chain_drv: a DIV=2 instance carries most scenarios and
// a DIV=1 instance sharing the same inputs covers the fastest shift rate.
module tb_sft_chain_drv;

    logic       CLK_I = 1'b0;
    logic       RST_I = 1'b1;
    logic       wrVld = 1'b0;
    logic [1:0] wrCmd = 2'b00;
    logic       wrOen = 1'b0;
    logic [7:0] wrDin = 8'h00;
    logic       ovfClr = 1'b0;

    logic wrRdy, busy, done, ovf, shcp, ds, stcp, mrN, oeN;
    logic wrRdy1, busy1, done1, ovf1, shcp1, ds1, stcp1, mrN1, oeN1;

    int nCompared   = 0;
    int nMismatched = 0;

    logic       trkClear = 1'b1;
    logic       trkPrev = 1'b0, sawShcp = 1'b0, sawMr = 1'b0, sawSt = 1'b0;
    logic [3:0] evtQ[$];

    sft_chain_drv #(.DIV(2), .FIFO_DEPTH(4)) dutDiv2 (
        .CLK_I(CLK_I), .RST_I(RST_I), .wr_vld(wrVld), .wr_cmd(wrCmd), .wr_oen(wrOen),
        .wr_din(wrDin), .wr_rdy(wrRdy), .busy(busy), .done(done), .ovf(ovf),
        .ovf_clr(ovfClr), .sft_shcp(shcp), .sft_ds(ds), .sft_stcp(stcp),
        .sft_mr_n(mrN), .sft_oe_n(oeN)
    );

    sft_chain_drv #(.DIV(1), .FIFO_DEPTH(4)) dutDiv1 (
        .CLK_I(CLK_I), .RST_I(RST_I), .wr_vld(wrVld), .wr_cmd(wrCmd), .wr_oen(wrOen),
        .wr_din(wrDin), .wr_rdy(wrRdy1), .busy(busy1), .done(done1), .ovf(ovf1),
        .ovf_clr(ovfClr), .sft_shcp(shcp1), .sft_ds(ds1), .sft_stcp(stcp1),
        .sft_mr_n(mrN1), .sft_oe_n(oeN1)
    );

    always #5 CLK_I = ~CLK_I;

    // Per-command event log for the DIV=2 instance: {shcp rose, mr_n low, stcp high, oe_n at done}.
    always @(negedge CLK_I) begin
        if (trkClear) begin
            evtQ.delete();
            trkPrev <= 1'b0; sawShcp <= 1'b0; sawMr <= 1'b0; sawSt <= 1'b0;
        end else if (done) begin
            evtQ.push_back({sawShcp, sawMr, sawSt, oeN});
            trkPrev <= shcp; sawShcp <= 1'b0; sawMr <= 1'b0; sawSt <= 1'b0;
        end else begin
            trkPrev <= shcp;
            if (shcp && !trkPrev) sawShcp <= 1'b1;
            if (!mrN)             sawMr   <= 1'b1;
            if (stcp)             sawSt   <= 1'b1;
        end
    end

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic doReset();
        wrVld = 1'b0; ovfClr = 1'b0; RST_I = 1'b1; trkClear = 1'b1;
        tick();
        tick();
        RST_I = 1'b0; trkClear = 1'b0;
    endtask

    task automatic applyStimulus(input logic [1:0] cmd, input logic oen, input logic [7:0] din);
        wrVld = 1'b1; wrCmd = cmd; wrOen = oen; wrDin = din;
        tick();
        wrVld = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        nCompared++;
        if ({shcp, ds, stcp, mrN, oeN} !== 5'b00011) begin
            nMismatched++; $display("[TB] FAIL reset_pins: got %b, expected 00011", {shcp, ds, stcp, mrN, oeN});
        end
        nCompared++;
        if ({done, busy, wrRdy, ovf} !== 4'b0010) begin
            nMismatched++; $display("[TB] FAIL reset_status: got %b, expected 0010", {done, busy, wrRdy, ovf});
        end
        nCompared++;
        if ({shcp1, ds1, stcp1, mrN1, oeN1, done1, busy1, wrRdy1, ovf1} !== 9'b000110010) begin
            nMismatched++; $display("[TB] FAIL reset_div1: got %b, expected 000110010",
                                    {shcp1, ds1, stcp1, mrN1, oeN1, done1, busy1, wrRdy1, ovf1});
        end
    endtask

    task automatic test_shift();
        logic [7:0] expByte = 8'hA5;
        int rises = 0, doneAt = -1;
        logic prev = 1'b0;
        doReset();
        applyStimulus(2'b01, 1'b0, 8'hA5);
        nCompared++;
        if (busy !== 1'b1) begin
            nMismatched++; $display("[TB] FAIL shift_busy: got %b, expected 1", busy);
        end
        for (int c = 1; c <= 60 && doneAt < 0; c++) begin
            tick();
            if (shcp && !prev) begin
                if (rises < 8) begin
                    nCompared++;
                    if (ds !== expByte[7 - rises]) begin
                        nMismatched++; $display("[TB] FAIL shift_ds_bit%0d: got %b, expected %b", rises, ds, expByte[7 - rises]);
                    end
                    nCompared++;
                    if (c !== 4 + 4 * rises) begin
                        nMismatched++; $display("[TB] FAIL shift_rise%0d_cycle: got %0d, expected %0d", rises, c, 4 + 4 * rises);
                    end
                end
                rises++;
            end
            prev = shcp;
            if (done) doneAt = c;
        end
        nCompared++;
        if (rises !== 8) begin
            nMismatched++; $display("[TB] FAIL shift_rise_count: got %0d, expected 8", rises);
        end
        nCompared++;
        if (doneAt !== 34) begin
            nMismatched++; $display("[TB] FAIL shift_done_cycle: got %0d, expected 34", doneAt);
        end
        nCompared++;
        if ({shcp, ds} !== 2'b00) begin
            nMismatched++; $display("[TB] FAIL shift_idle_pins: got %b, expected 00", {shcp, ds});
        end
    endtask

    task automatic test_mr_st();
        int mrFirst = -1, mrCnt = 0, stFirst = -1, stCnt = 0, doneCnt = 0, done1At = -1, done2At = -1;
        doReset();
        applyStimulus(2'b00, 1'b0, 8'h00);
        applyStimulus(2'b10, 1'b0, 8'h00);
        for (int c = 2; c <= 40; c++) begin
            tick();
            if (!mrN) begin if (mrFirst < 0) mrFirst = c; mrCnt++; end
            if (stcp) begin if (stFirst < 0) stFirst = c; stCnt++; end
            if (done) begin
                doneCnt++;
                if (doneCnt == 1) done1At = c; else if (doneCnt == 2) done2At = c;
            end
        end
        nCompared++;
        if (mrFirst !== 2 || mrCnt !== 4) begin
            nMismatched++; $display("[TB] FAIL mr_pulse: got start %0d len %0d, expected start 2 len 4", mrFirst, mrCnt);
        end
        nCompared++;
        if (done1At !== 6) begin
            nMismatched++; $display("[TB] FAIL mr_done_cycle: got %0d, expected 6", done1At);
        end
        nCompared++;
        if (stFirst !== 9 || stCnt !== 4) begin
            nMismatched++; $display("[TB] FAIL st_pulse: got start %0d len %0d, expected start 9 len 4", stFirst, stCnt);
        end
        nCompared++;
        if (done2At !== 13 || doneCnt !== 2) begin
            nMismatched++; $display("[TB] FAIL st_done: got cycle %0d count %0d, expected cycle 13 count 2", done2At, doneCnt);
        end
    endtask

    task automatic test_oe();
        logic sawHigh = 1'b0, sawMrLow = 1'b0, sawDone = 1'b0;
        doReset();
        applyStimulus(2'b11, 1'b0, 8'h00);
        tick();
        nCompared++;
        if ({oeN, done} !== 2'b10) begin
            nMismatched++; $display("[TB] FAIL oe_cycle1: got %b, expected 10", {oeN, done});
        end
        tick();
        nCompared++;
        if ({oeN, done} !== 2'b01) begin
            nMismatched++; $display("[TB] FAIL oe_cycle2: got %b, expected 01", {oeN, done});
        end
        tick();
        nCompared++;
        if (done !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL oe_done_width: got %b, expected 0", done);
        end
        applyStimulus(2'b00, 1'b0, 8'h00);
        for (int c = 1; c <= 20 && !sawDone; c++) begin
            tick();
            if (oeN)  sawHigh  = 1'b1;
            if (!mrN) sawMrLow = 1'b1;
            if (done) sawDone  = 1'b1;
        end
        nCompared++;
        if ({sawDone, sawMrLow, sawHigh} !== 3'b110) begin
            nMismatched++; $display("[TB] FAIL oe_kept_over_mr: got done/mr/oeHigh %b, expected 110", {sawDone, sawMrLow, sawHigh});
        end
    endtask

    task automatic test_overflow();
        logic [1:0] cmds [5] = '{2'b11, 2'b00, 2'b11, 2'b10, 2'b11};
        logic       oens [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0] expEvt [5] = '{4'b1001, 4'b0000, 4'b0100, 4'b0001, 4'b0011};
        doReset();
        applyStimulus(2'b01, 1'b0, 8'hA5);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            wrVld = 1'b1; wrCmd = cmds[i]; wrOen = oens[i]; wrDin = 8'h00;
            nCompared++;
            if (wrRdy !== logic'(i < 4)) begin
                nMismatched++; $display("[TB] FAIL ovf_wr_rdy%0d: got %b, expected %b", i, wrRdy, logic'(i < 4));
            end
            tick();
        end
        wrVld = 1'b0;
        nCompared++;
        if (ovf !== 1'b1) begin
            nMismatched++; $display("[TB] FAIL ovf_set: got %b, expected 1", ovf);
        end
        wrVld = 1'b1; wrCmd = 2'b11; wrOen = 1'b0; ovfClr = 1'b1;
        tick();
        wrVld = 1'b0; ovfClr = 1'b0;
        nCompared++;
        if (ovf !== 1'b1) begin
            nMismatched++; $display("[TB] FAIL ovf_set_beats_clr: got %b, expected 1", ovf);
        end
        ovfClr = 1'b1;
        tick();
        ovfClr = 1'b0;
        nCompared++;
        if (ovf !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL ovf_clear: got %b, expected 0", ovf);
        end
        for (int c = 0; c < 120; c++) tick();
        nCompared++;
        if (evtQ.size() !== 5) begin
            nMismatched++; $display("[TB] FAIL ovf_cmd_count: got %0d, expected 5", evtQ.size());
        end
        for (int i = 0; i < 5 && i < evtQ.size(); i++) begin
            nCompared++;
            if (evtQ[i] !== expEvt[i]) begin
                nMismatched++; $display("[TB] FAIL ovf_order%0d: got %b, expected %b", i, evtQ[i], expEvt[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int rises = 0, doneCnt = 0, stCnt = 0;
        logic prev = 1'b0, sawDone = 1'b0;
        doReset();
        applyStimulus(2'b01, 1'b0, 8'hFF);
        applyStimulus(2'b10, 1'b0, 8'h00);
        for (int c = 2; c <= 40 && rises < 3; c++) begin
            tick();
            if (shcp && !prev) rises++;
            prev = shcp;
        end
        nCompared++;
        if ({rises, shcp, ds} !== {32'd3, 2'b11}) begin
            nMismatched++; $display("[TB] FAIL mid_before_reset: got rises %0d pins %b, expected 3 / 11", rises, {shcp, ds});
        end
        #2;
        RST_I = 1'b1;
        #1;
        nCompared++;
        if ({shcp, ds, stcp, mrN, oeN, done, busy, wrRdy} !== 8'b00011001) begin
            nMismatched++; $display("[TB] FAIL mid_async_reset: got %b, expected 00011001",
                                    {shcp, ds, stcp, mrN, oeN, done, busy, wrRdy});
        end
        @(posedge CLK_I);
        #1;
        RST_I = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done) doneCnt++;
            if (stcp) stCnt++;
        end
        nCompared++;
        if (doneCnt !== 0 || stCnt !== 0) begin
            nMismatched++; $display("[TB] FAIL mid_discard: got dones %0d stcp %0d, expected 0 / 0", doneCnt, stCnt);
        end
        applyStimulus(2'b11, 1'b0, 8'h00);
        for (int c = 1; c <= 10 && !sawDone; c++) begin
            tick();
            if (done) sawDone = 1'b1;
        end
        nCompared++;
        if ({sawDone, oeN} !== 2'b10) begin
            nMismatched++; $display("[TB] FAIL mid_after_reset: got done/oe_n %b, expected 10", {sawDone, oeN});
        end
    endtask

    task automatic test_div1();
        int rises = 0, doneCnt = 0, done1At = -1, done2At = -1;
        logic prev = 1'b0;
        doReset();
        applyStimulus(2'b01, 1'b0, 8'hFF);
        applyStimulus(2'b01, 1'b0, 8'h00);
        for (int c = 2; c <= 80 && doneCnt < 2; c++) begin
            tick();
            if (shcp1 && !prev) begin
                if (rises < 16) begin
                    nCompared++;
                    if (ds1 !== logic'(rises < 8)) begin
                        nMismatched++; $display("[TB] FAIL div1_ds%0d: got %b, expected %b", rises, ds1, logic'(rises < 8));
                    end
                    nCompared++;
                    if (c !== ((rises < 8) ? 3 + 2 * rises : 22 + 2 * (rises - 8))) begin
                        nMismatched++; $display("[TB] FAIL div1_rise%0d_cycle: got %0d, expected %0d", rises, c,
                                                (rises < 8) ? 3 + 2 * rises : 22 + 2 * (rises - 8));
                    end
                end
                rises++;
            end
            prev = shcp1;
            if (done1) begin
                doneCnt++;
                if (doneCnt == 1) done1At = c; else done2At = c;
            end
        end
        nCompared++;
        if (rises !== 16) begin
            nMismatched++; $display("[TB] FAIL div1_rise_count: got %0d, expected 16", rises);
        end
        nCompared++;
        if (done1At !== 18 || done2At !== 37) begin
            nMismatched++; $display("[TB] FAIL div1_done_cycles: got %0d and %0d, expected 18 and 37", done1At, done2At);
        end
    endtask

    initial begin
        test_reset();
        test_shift();
        test_mr_st();
        test_oe();
        test_overflow();
        test_reset_mid();
        test_div1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
